sample_iterator: RTL and testbench

Sample-grid iterator that walks every subsample position inside a triangle's bounding box. It is the producer for the sample-test stage. It accepts one triangle per handshake from the bounding-box stage and stalls that stage while iterating. It emits one candidate sample per cycle, together with the triangle and its color, into the non-stalling sample-test pipeline.

---
 rtl/sample_iterator.sv | 123 ++++++++++++
 tb/tb_sample_iterator.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sample_iterator.sv
// sample_iterator: walks every subsample position of a triangle's bounding box, one per cycle.
// Latency: accept at edge t gives the first sample valid in cycle t+1. An N-sample box ends in cycle t+N.
// Backpressure: halt_RnnnnH stalls the bbox stage while iterating. The downstream side has none.
// Ports:
//   clk, rst (async active-low)
//   tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU : triangle, box and step select in
//   halt_RnnnnH : stall to the bbox stage
//   tri_R14S, color_R14U, sample_R14S, validSamp_R14H : latched triangle and color, current sample
module sample_iterator #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]     tri_R13S,
  input  logic [COLORS-1:0][SIGFIG-1:0]              color_R13U,
  input  logic [1:0][1:0][SIGFIG-1:0]                box_R13S,
  input  logic                                       validTri_R13H,
  input  logic [3:0]                                 subSample_RnnnnU,
  output logic                                       halt_RnnnnH,
  output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]     tri_R14S,
  output logic [COLORS-1:0][SIGFIG-1:0]              color_R14U,
  output logic [1:0][SIGFIG-1:0]                     sample_R14S,
  output logic                                       validSamp_R14H
);

  typedef enum logic {WAIT = 1'b0, TEST = 1'b1} state_t;

  localparam logic signed [SIGFIG-1:0] ONE = 1;

  state_t                                r_state;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] r_tri;
  logic [COLORS-1:0][SIGFIG-1:0]          r_color;
  logic signed [SIGFIG-1:0]              r_ll_x;
  logic signed [SIGFIG-1:0]              r_ur_x;
  logic signed [SIGFIG-1:0]              r_ur_y;
  logic signed [SIGFIG-1:0]              r_step;
  logic signed [SIGFIG-1:0]              r_x;
  logic signed [SIGFIG-1:0]              r_y;
  logic                                  r_vld;

  logic signed [SIGFIG-1:0]              w_ll_x;
  logic signed [SIGFIG-1:0]              w_ll_y;
  logic signed [SIGFIG-1:0]              w_ur_x;
  logic signed [SIGFIG-1:0]              w_ur_y;
  logic signed [SIGFIG-1:0]              w_step;
  logic                                  w_last;
  logic                                  w_halt;
  logic                                  w_accept;
  logic                                  w_empty;

  assign w_ll_x = box_R13S[0][0];
  assign w_ll_y = box_R13S[0][1];
  assign w_ur_x = box_R13S[1][0];
  assign w_ur_y = box_R13S[1][1];

  // Non-one-hot selects fall back to a whole-pixel step.
  always_comb begin
    w_step = ONE << RADIX;
    case (subSample_RnnnnU)
      4'b1000: w_step = ONE << RADIX;
      4'b0100: w_step = ONE << (RADIX - 1);
      4'b0010: w_step = ONE << (RADIX - 2);
      4'b0001: w_step = ONE << (RADIX - 3);
      default: w_step = ONE << RADIX;
    endcase
  end

  // halt is derived only from registers, so an async reset drops it without a clock.
  assign w_last   = (r_x >= r_ur_x) && (r_y >= r_ur_y);
  assign w_halt   = (r_state == TEST) && !w_last;
  assign w_accept = validTri_R13H && !w_halt;
  assign w_empty  = (w_ur_x < w_ll_x) || (w_ur_y < w_ll_y);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= WAIT;
      r_tri   <= '0;
      r_color <= '0;
      r_ll_x  <= '0;
      r_ur_x  <= '0;
      r_ur_y  <= '0;
      r_step  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_vld   <= 1'b0;
    end else if (w_accept && !w_empty) begin
      // A new box loads even on the previous box's last sample, so there is no bubble.
      r_state <= TEST;
      r_tri   <= tri_R13S;
      r_color <= color_R13U;
      r_ll_x  <= w_ll_x;
      r_ur_x  <= w_ur_x;
      r_ur_y  <= w_ur_y;
      r_step  <= w_step;
      r_x     <= w_ll_x;
      r_y     <= w_ll_y;
      r_vld   <= 1'b1;
    end else if (r_state == TEST) begin
      if (r_x < r_ur_x) begin
        r_x <= r_x + r_step;
      end else if (r_y < r_ur_y) begin
        r_x <= r_ll_x;
        r_y <= r_y + r_step;
      end else begin
        // Last sample with no new box to take, or an empty box to drop.
        r_state <= WAIT;
        r_vld   <= 1'b0;
      end
    end
  end

  assign halt_RnnnnH    = w_halt;
  assign tri_R14S       = r_tri;
  assign color_R14U     = r_color;
  assign sample_R14S[0] = r_x;
  assign sample_R14S[1] = r_y;
  assign validSamp_R14H = r_vld;

endmodule

// File: tb/tb_sample_iterator.sv
// Testbench for sample_iterator: directed boxes with hand-computed sample sequences.
// Inputs are driven 1 time unit after the rising edge, and outputs are checked there.
module tb_sample_iterator;

  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;

  logic                                   clk;
  logic                                   rst;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_in;
  logic [COLORS-1:0][SIGFIG-1:0]          color_in;
  logic [1:0][1:0][SIGFIG-1:0]            box_in;
  logic                                   valid_tri;
  logic [3:0]                             sub_sample;
  logic                                   halt;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_out;
  logic [COLORS-1:0][SIGFIG-1:0]          color_out;
  logic [1:0][SIGFIG-1:0]                 sample_out;
  logic                                   valid_samp;

  int n_checks = 0;
  int n_errors = 0;

  sample_iterator #(
    .SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .tri_R13S         (tri_in),
    .color_R13U       (color_in),
    .box_R13S         (box_in),
    .validTri_R13H    (valid_tri),
    .subSample_RnnnnU (sub_sample),
    .halt_RnnnnH      (halt),
    .tri_R14S         (tri_out),
    .color_R14U       (color_out),
    .sample_R14S      (sample_out),
    .validSamp_R14H   (valid_samp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_box(input int llx, input int lly, input int urx, input int ury,
                         input logic [3:0] sub);
    box_in[0][0] = SIGFIG'(llx);
    box_in[0][1] = SIGFIG'(lly);
    box_in[1][0] = SIGFIG'(urx);
    box_in[1][1] = SIGFIG'(ury);
    sub_sample   = sub;
  endtask

  task automatic set_tri(input int base);
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        tri_in[v][a] = SIGFIG'(base + v * AXIS + a);
    for (int c = 0; c < COLORS; c++)
      color_in[c] = SIGFIG'(base + 100 + c);
  endtask

  // One expected output cycle: valid, halt and the sample position.
  task automatic expect_samp(input string tag, input logic v, input logic h,
                             input int x, input int y);
    check({tag, ".vld"},  valid_samp, v);
    check({tag, ".halt"}, halt, h);
    if (v) begin
      check({tag, ".x"}, sample_out[0], SIGFIG'(x));
      check({tag, ".y"}, sample_out[1], SIGFIG'(y));
    end
  endtask

  logic [COLORS-1:0][SIGFIG-1:0]          exp_color;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] exp_tri;

  initial begin
    rst = 1'b0;
    valid_tri = 1'b0;
    tri_in = '0;
    color_in = '0;
    box_in = '0;
    sub_sample = 4'b1000;

    // Reset state.
    tick();
    expect_samp("rst", 1'b0, 1'b0, 0, 0);
    check("rst.sample", sample_out, '0);
    check("rst.color", color_out, '0);
    check("rst.tri", tri_out, '0);
    rst = 1'b1;
    tick();
    tick();
    expect_samp("idle", 1'b0, 1'b0, 0, 0);

    // A single sample: halt never rises.
    set_tri(10);
    set_box(0, 0, 0, 0, 4'b1000);
    valid_tri = 1'b1;
    tick();
    expect_samp("one.s0", 1'b1, 1'b0, 0, 0);
    exp_color = color_in;
    exp_tri = tri_in;
    check("one.color", color_out, exp_color);
    check("one.tri", tri_out, exp_tri);
    valid_tri = 1'b0;
    tick();
    expect_samp("one.end", 1'b0, 1'b0, 0, 0);

    // A 2x2 pixel box. The input box is corrupted while halt is high and must be ignored.
    set_box(1024, 2048, 2048, 3072, 4'b1000);
    valid_tri = 1'b1;
    tick();
    expect_samp("px.s0", 1'b1, 1'b1, 1024, 2048);
    valid_tri = 1'b0;
    set_box(7, 7, 9, 9, 4'b0001);
    tick();
    expect_samp("px.s1", 1'b1, 1'b1, 2048, 2048);
    tick();
    expect_samp("px.s2", 1'b1, 1'b1, 1024, 3072);
    tick();
    expect_samp("px.s3", 1'b1, 1'b0, 2048, 3072);
    tick();
    expect_samp("px.end", 1'b0, 1'b0, 0, 0);

    // Back-to-back boxes: A at half-pixel step, then B is held valid throughout.
    set_tri(20);
    set_box(0, 0, 512, 512, 4'b0100);
    valid_tri = 1'b1;
    tick();
    expect_samp("a.s0", 1'b1, 1'b1, 0, 0);
    exp_color = color_in;
    set_tri(40);
    set_box(4096, 0, 4096, 0, 4'b1000);
    tick();
    expect_samp("a.s1", 1'b1, 1'b1, 512, 0);
    tick();
    expect_samp("a.s2", 1'b1, 1'b1, 0, 512);
    tick();
    expect_samp("a.s3", 1'b1, 1'b0, 512, 512);
    check("a.color", color_out, exp_color);
    tick();
    expect_samp("b.s0", 1'b1, 1'b0, 4096, 0);
    exp_color = color_in;
    exp_tri = tri_in;
    check("b.color", color_out, exp_color);
    check("b.tri", tri_out, exp_tri);
    valid_tri = 1'b0;
    tick();
    expect_samp("b.end", 1'b0, 1'b0, 0, 0);

    // An empty box is dropped, and the next box is accepted normally.
    set_box(2048, 0, 1024, 0, 4'b1000);
    valid_tri = 1'b1;
    tick();
    expect_samp("empty.0", 1'b0, 1'b0, 0, 0);
    tick();
    expect_samp("empty.1", 1'b0, 1'b0, 0, 0);
    set_box(3072, 1024, 3072, 1024, 4'b1000);
    tick();
    expect_samp("post.s0", 1'b1, 1'b0, 3072, 1024);
    valid_tri = 1'b0;
    tick();
    expect_samp("post.end", 1'b0, 1'b0, 0, 0);

    // A non-one-hot select behaves as a whole-pixel step.
    set_box(0, 0, 1024, 0, 4'b0110);
    valid_tri = 1'b1;
    tick();
    expect_samp("nh.s0", 1'b1, 1'b1, 0, 0);
    valid_tri = 1'b0;
    tick();
    expect_samp("nh.s1", 1'b1, 1'b0, 1024, 0);
    tick();
    expect_samp("nh.end", 1'b0, 1'b0, 0, 0);

    // Reset arrives mid-triangle, then a new box runs at a re-latched 1/8 step.
    set_box(0, 0, 2048, 2048, 4'b1000);
    valid_tri = 1'b1;
    tick();
    expect_samp("mr.s0", 1'b1, 1'b1, 0, 0);
    valid_tri = 1'b0;
    tick();
    expect_samp("mr.s1", 1'b1, 1'b1, 1024, 0);
    tick();
    expect_samp("mr.s2", 1'b1, 1'b1, 2048, 0);
    #2 rst = 1'b0;
    #1;
    expect_samp("mr.rst", 1'b0, 1'b0, 0, 0);
    check("mr.rst.sample", sample_out, '0);
    tick();
    rst = 1'b1;
    set_box(5120, 1024, 5248, 1024, 4'b0001);
    valid_tri = 1'b1;
    tick();
    expect_samp("mr.n0", 1'b1, 1'b1, 5120, 1024);
    valid_tri = 1'b0;
    tick();
    expect_samp("mr.n1", 1'b1, 1'b0, 5248, 1024);
    tick();
    expect_samp("mr.end", 1'b0, 1'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
